// File: rtl/dns_sched_pkg.sv
// Shared types and constants for the DNS matrix-array job scheduler.
package dns_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COPYA = 3'd1,
    COPYB = 3'd2,
    BROAD = 3'd3,
    MUL   = 3'd4,
    SUM   = 3'd5,
    RESP  = 3'd6
  } dns_phase_e;

  localparam int DNS_N = 4;
  localparam int DNS_W = 8;

endpackage

// File: rtl/dns_sched_if.sv
// Requester/array handshake bundle for dns_sched.
// The slave side is the scheduler; the master side is the host/array environment.
interface dns_sched_if #(
  parameter  int NREQ = dns_pkg::DNS_N,
  localparam int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  sel_id;
  logic            load_a;
  logic            load_b;
  logic            bcast;
  logic            mul_en;
  logic            sum_en;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_ready;
  logic            busy;

  modport master (
    output req_valid, resp_ready,
    input  gnt, sel_id, load_a, load_b, bcast, mul_en, sum_en,
    input  resp_valid, resp_id, busy
  );

  modport slave (
    input  req_valid, resp_ready,
    output gnt, sel_id, load_a, load_b, bcast, mul_en, sum_en,
    output resp_valid, resp_id, busy
  );
endinterface

// File: rtl/dns_sched_rr_arb.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, ... mod NREQ.
module dns_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_win,
  output logic            o_any
);

  logic [IDW-1:0]  w_idx [NREQ];
  logic [NREQ-1:0] w_rot;

  // w_rot[k] is the request at offset k from the pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW:0] w_sum;
    assign w_sum      = {1'b0, i_ptr} + (IDW+1)'(gi);
    assign w_idx[gi]  = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                  : IDW'(w_sum);
    assign w_rot[gi]  = i_req[w_idx[gi]];
  end

  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_win = w_idx[k];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dns_sched.sv
// Round-robin job scheduler sequencing a shared DNS array COPYA->COPYB->BROAD->MUL->SUM->RESP.
// Optional perf counters (perf_jobs, perf_busy) when DNS_SCHED_PERF_EN is defined.
module dns_sched
  import dns_pkg::*;
#(
  parameter int NREQ    = DNS_N,
  parameter int MUL_CYC = 1,
  parameter int SUM_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  dns_sched_if.slave  bus
`ifdef DNS_SCHED_PERF_EN
  ,
  output logic [15:0] perf_jobs,
  output logic [31:0] perf_busy
`endif
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CMAX = (MUL_CYC > SUM_CYC) ? MUL_CYC : SUM_CYC;
  localparam int CNTW = $clog2(CMAX + 1);

  dns_phase_e      r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_sel_id;
  logic [IDW-1:0]  r_resp_id;
  logic [NREQ-1:0] r_gnt;
  logic            r_load_a;
  logic            r_load_b;
  logic            r_bcast;
  logic            r_mul_en;
  logic            r_sum_en;
  logic            r_resp_valid;
  logic            r_busy;
  logic [CNTW-1:0] r_cnt;

  logic [IDW-1:0]  w_win;
  logic            w_any;
  logic [NREQ-1:0] w_onehot;
  logic            w_accept;

  dns_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_win == IDW'(gi));
  end

  assign w_accept = r_resp_valid && bus.resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_sel_id     <= '0;
      r_resp_id    <= '0;
      r_gnt        <= '0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_bcast      <= 1'b0;
      r_mul_en     <= 1'b0;
      r_sum_en     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= COPYA;
            r_gnt    <= w_onehot;
            r_sel_id <= w_win;
            r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            r_load_a <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        COPYA: begin
          r_load_a <= 1'b0;
          r_load_b <= 1'b1;
          r_state  <= COPYB;
        end
        COPYB: begin
          r_load_b <= 1'b0;
          r_bcast  <= 1'b1;
          r_state  <= BROAD;
        end
        BROAD: begin
          r_bcast  <= 1'b0;
          r_mul_en <= 1'b1;
          r_cnt    <= CNTW'(MUL_CYC - 1);
          r_state  <= MUL;
        end
        MUL: begin
          // r_cnt holds the remaining extra cycles of the current strobe.
          if (r_cnt == '0) begin
            r_mul_en <= 1'b0;
            r_sum_en <= 1'b1;
            r_cnt    <= CNTW'(SUM_CYC - 1);
            r_state  <= SUM;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SUM: begin
          if (r_cnt == '0) begin
            r_sum_en     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_sel_id;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (w_accept) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_load_a     <= 1'b0;
          r_load_b     <= 1'b0;
          r_bcast      <= 1'b0;
          r_mul_en     <= 1'b0;
          r_sum_en     <= 1'b0;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.sel_id     = r_sel_id;
  assign bus.load_a     = r_load_a;
  assign bus.load_b     = r_load_b;
  assign bus.bcast      = r_bcast;
  assign bus.mul_en     = r_mul_en;
  assign bus.sum_en     = r_sum_en;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.busy       = r_busy;

`ifdef DNS_SCHED_PERF_EN
  logic [15:0] r_perf_jobs;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_jobs <= '0;
      r_perf_busy <= '0;
    end else begin
      if (r_state == RESP && w_accept) begin
        r_perf_jobs <= r_perf_jobs + 16'd1;
      end
      if (r_busy && r_perf_busy != 32'hFFFF_FFFF) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
    end
  end

  assign perf_jobs = r_perf_jobs;
  assign perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_dns_sched.sv
// Directed bench for dns_sched: vector table for a single job, hand sequences for
// fairness, backpressure, latency parameters, mid-job reset and optional perf counters.
module tb_dns_sched;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dns_sched_if #(.NREQ(4)) bus0 ();
  dns_sched_if #(.NREQ(4)) bus1 ();

`ifdef DNS_SCHED_PERF_EN
  logic [15:0] perf_jobs0, perf_jobs1;
  logic [31:0] perf_busy0, perf_busy1;
`endif

  dns_sched #(.NREQ(4), .MUL_CYC(1), .SUM_CYC(1)) u0 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0)
`ifdef DNS_SCHED_PERF_EN
    ,
    .perf_jobs (perf_jobs0),
    .perf_busy (perf_busy0)
`endif
  );

  dns_sched #(.NREQ(4), .MUL_CYC(3), .SUM_CYC(2)) u1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1)
`ifdef DNS_SCHED_PERF_EN
    ,
    .perf_jobs (perf_jobs1),
    .perf_busy (perf_busy1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [4:0] strb;
    logic       rv;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] strobes0();
    return {bus0.load_a, bus0.load_b, bus0.bcast, bus0.mul_en, bus0.sum_en};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus0.req_valid = '0;
    bus1.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle0();
    for (int i = 0; i < 20 && bus0.busy; i++) tick();
    check("idle_reached", 32'(bus0.busy), 32'd0);
  endtask

  task automatic check_all_zero0(input string tag);
    check({tag, "_gnt"},  32'(bus0.gnt), 32'd0);
    check({tag, "_strb"}, 32'(strobes0()), 32'd0);
    check({tag, "_rv"},   32'(bus0.resp_valid), 32'd0);
    check({tag, "_sel"},  32'(bus0.sel_id), 32'd0);
    check({tag, "_rid"},  32'(bus0.resp_id), 32'd0);
    check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ngr;
    int         last;
    int         nm;
    int         ns;
    int         rvk;
    logic [3:0] expg;

    n_tests = 0;
    n_fail  = 0;

    //            req      rdy   gnt      strobes   rv    id    busy
    tbl[0] = '{4'b0100, 1'b0, 4'b0100, 5'b10000, 1'b0, 2'd2, 1'b1};
    tbl[1] = '{4'b0000, 1'b0, 4'b0000, 5'b01000, 1'b0, 2'd2, 1'b1};
    tbl[2] = '{4'b0000, 1'b0, 4'b0000, 5'b00100, 1'b0, 2'd2, 1'b1};
    tbl[3] = '{4'b0000, 1'b0, 4'b0000, 5'b00010, 1'b0, 2'd2, 1'b1};
    tbl[4] = '{4'b0000, 1'b0, 4'b0000, 5'b00001, 1'b0, 2'd2, 1'b1};
    tbl[5] = '{4'b0000, 1'b0, 4'b0000, 5'b00000, 1'b1, 2'd2, 1'b1};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 5'b00000, 1'b0, 2'd2, 1'b0};
    tbl[7] = '{4'b0100, 1'b0, 4'b0100, 5'b10000, 1'b0, 2'd2, 1'b1};

    rst = 1'b1;
    bus0.req_valid  = '0;
    bus0.resp_ready = 1'b0;
    bus1.req_valid  = '0;
    bus1.resp_ready = 1'b0;
    repeat (2) tick();
    check_all_zero0("reset");
    check("reset_u1_busy", 32'(bus1.busy), 32'd0);
    rst = 1'b0;

    // Single job, request dropped after grant, then a fresh request.
    for (int r = 0; r < 8; r++) begin
      bus0.req_valid  = tbl[r].req;
      bus0.resp_ready = tbl[r].rdy;
      tick();
      $display("[TB] vec %0d req=%b gnt=%b strb=%b rv=%b rid=%0d sel=%0d busy=%b",
               r, tbl[r].req, bus0.gnt, strobes0(), bus0.resp_valid,
               bus0.resp_id, bus0.sel_id, bus0.busy);
      check($sformatf("vec%0d_gnt", r),  32'(bus0.gnt), 32'(tbl[r].gnt));
      check($sformatf("vec%0d_strb", r), 32'(strobes0()), 32'(tbl[r].strb));
      check($sformatf("vec%0d_rv", r),   32'(bus0.resp_valid), 32'(tbl[r].rv));
      check($sformatf("vec%0d_busy", r), 32'(bus0.busy), 32'(tbl[r].busy));
      if (tbl[r].busy) check($sformatf("vec%0d_sel", r), 32'(bus0.sel_id), 32'(tbl[r].id));
      if (tbl[r].rv)   check($sformatf("vec%0d_rid", r), 32'(bus0.resp_id), 32'(tbl[r].id));
    end

    // Fairness with every requester asserting continuously.
    do_reset();
    bus0.req_valid  = 4'b1111;
    bus0.resp_ready = 1'b1;
    ngr  = 0;
    last = 0;
    for (int cyc = 0; cyc < 80 && ngr < 5; cyc++) begin
      tick();
      if (bus0.gnt != 4'b0000) begin
        expg = 4'(1 << (ngr % 4));
        $display("[TB] fair grant %0d gnt=%b cycle=%0d", ngr, bus0.gnt, cyc);
        check("fair_gnt", 32'(bus0.gnt), 32'(expg));
        if (ngr > 0) check("fair_gap", 32'(cyc - last), 32'd7);
        last = cyc;
        ngr++;
      end
    end
    check("fair_count", 32'(ngr), 32'd5);
    bus0.req_valid = '0;
    wait_idle0();

    // Backpressure in RESP.
    do_reset();
    bus0.req_valid  = 4'b0001;
    bus0.resp_ready = 1'b0;
    tick();
    bus0.req_valid = '0;
    for (int i = 0; i < 12 && !bus0.resp_valid; i++) tick();
    check("bp_rv_arrive", 32'(bus0.resp_valid), 32'd1);
    bus0.req_valid = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("[TB] stall %0d rv=%b rid=%0d gnt=%b busy=%b",
               i, bus0.resp_valid, bus0.resp_id, bus0.gnt, bus0.busy);
      check("bp_rv",   32'(bus0.resp_valid), 32'd1);
      check("bp_rid",  32'(bus0.resp_id), 32'd0);
      check("bp_gnt",  32'(bus0.gnt), 32'd0);
      check("bp_busy", 32'(bus0.busy), 32'd1);
    end
    bus0.resp_ready = 1'b1;
    tick();
    check("bp_accept_rv",   32'(bus0.resp_valid), 32'd0);
    check("bp_accept_busy", 32'(bus0.busy), 32'd0);
    check("bp_accept_gnt",  32'(bus0.gnt), 32'd0);
    tick();
    check("bp_next_gnt", 32'(bus0.gnt), 32'b0010);
    bus0.req_valid = '0;
    wait_idle0();

    // Longer multiply/reduction latencies on the second instance.
    do_reset();
    bus1.req_valid  = 4'b0100;
    bus1.resp_ready = 1'b0;
    nm  = 0;
    ns  = 0;
    rvk = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus1.req_valid = '0;
      if (bus1.mul_en) nm++;
      if (bus1.sum_en) ns++;
      if (bus1.resp_valid && rvk == 0) rvk = k;
    end
    $display("[TB] latency job mul=%0d sum=%0d resp_at=t+%0d", nm, ns, rvk);
    check("lat_mul_cycles", 32'(nm), 32'd3);
    check("lat_sum_cycles", 32'(ns), 32'd2);
    check("lat_resp_at",    32'(rvk), 32'd9);
    check("lat_rid",        32'(bus1.resp_id), 32'd2);
    bus1.resp_ready = 1'b1;
    tick();
    check("lat_accept_rv", 32'(bus1.resp_valid), 32'd0);

    // Reset while the array is multiplying.
    do_reset();
    bus0.req_valid  = 4'b0100;
    bus0.resp_ready = 1'b1;
    tick();
    bus0.req_valid = '0;
    for (int i = 0; i < 10 && !bus0.mul_en; i++) tick();
    check("rst_reach_mul", 32'(bus0.mul_en), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero0("midrst");
    rst = 1'b0;
    bus0.req_valid = 4'b1010;
    tick();
    $display("[TB] post-reset grant gnt=%b", bus0.gnt);
    check("midrst_gnt", 32'(bus0.gnt), 32'b0010);
    bus0.req_valid = '0;
    wait_idle0();

`ifdef DNS_SCHED_PERF_EN
    do_reset();
    bus0.resp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus0.req_valid = 4'b0001;
      tick();
      bus0.req_valid = '0;
      wait_idle0();
    end
    $display("[TB] perf jobs=%0d busy=%0d", perf_jobs0, perf_busy0);
    check("perf_jobs", 32'(perf_jobs0), 32'd3);
    check("perf_busy", perf_busy0, 32'd18);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
